// File: rtl/sid_write_queue_if.sv
// Host-to-SID write-queue bus: entry push handshake, clkEn timebase and SID write port.
// Latency: none, signal bundle only.
// Backpressure: oReady low means the queue is full; the host holds iValid until it rises.
// Ports: slave = queue side (takes entries, drives the SID write port), master = host/bench side.
// Optional macro SID_WRQ_PAUSE_EN adds iPause (host -> queue).
interface sid_write_queue_if #(
    parameter int DEPTH   = 256,
    parameter int DELAY_W = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic               clkEn;
    logic               iValid;
    logic               oReady;
    logic [DELAY_W-1:0] iDelay;
    logic [4:0]         iAddr;
    logic [7:0]         iData;
    logic               iFlush;
    logic               oWE;
    logic [4:0]         oAddr;
    logic [7:0]         oDataW;
    logic [LW-1:0]      oLevel;
`ifdef SID_WRQ_PAUSE_EN
    logic               iPause;

    modport master (
        output clkEn, iValid, iDelay, iAddr, iData, iFlush, iPause,
        input  oReady, oWE, oAddr, oDataW, oLevel
    );
    modport slave (
        input  clkEn, iValid, iDelay, iAddr, iData, iFlush, iPause,
        output oReady, oWE, oAddr, oDataW, oLevel
    );
`else
    modport master (
        output clkEn, iValid, iDelay, iAddr, iData, iFlush,
        input  oReady, oWE, oAddr, oDataW, oLevel
    );
    modport slave (
        input  clkEn, iValid, iDelay, iAddr, iData, iFlush,
        output oReady, oWE, oAddr, oDataW, oLevel
    );
`endif
endinterface

// File: rtl/sid_write_queue.sv
// Timed SID register-write scheduler: FIFO of (delay, addr, data) replayed as one-clk write strobes.
// Latency: delay-0 entry into an idle queue strobes oWE 4 clk after acceptance; back-to-back every 3 clk.
// Backpressure: oReady = not full; a LOAD frees a slot and oReady rises the following cycle.
// Ports: clk, iRstN (async active-low), bus (sid_write_queue_if.slave).
// Optional macro SID_WRQ_PAUSE_EN: iPause freezes the WAIT countdown and defers a pending issue.
module sid_write_queue #(
    parameter int DEPTH   = 256,
    parameter int DELAY_W = 16
) (
    input  logic             clk,
    input  logic             iRstN,
    sid_write_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DELAY_W + 13;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, ISSUE} state_t;

    state_t             state;
    logic [EW-1:0]      mem [DEPTH];
    logic [EW-1:0]      rd_dat;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      level;
    logic [DELAY_W-1:0] cnt;
    logic [4:0]         lat_addr;
    logic [7:0]         lat_data;
    logic               empty;
    logic               full;
    logic               push;
    logic               rd_en;
    logic               pause;

    // Pointers carry one extra bit so equal pointers unambiguously mean empty.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (level == PW'(DEPTH));
    assign bus.oReady = !full;
    assign bus.oLevel = level;

    // A push landing in the same cycle as a flush is discarded.
    assign push  = bus.iValid && !full && !bus.iFlush;
    // Reads are issued exactly on the transitions into LOAD.
    assign rd_en = !bus.iFlush && !empty && ((state == IDLE) || (state == ISSUE));

`ifdef SID_WRQ_PAUSE_EN
    assign pause = bus.iPause;
`else
    assign pause = 1'b0;
`endif

    // Storage RAM: one write port, one registered read port, no reset.
    // Read and write never share an address: reads need a non-empty
    // queue and writes need a non-full one.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {bus.iDelay, bus.iAddr, bus.iData};
        end
        if (rd_en) begin
            rd_dat <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_data   <= '0;
            bus.oWE    <= 1'b0;
            bus.oAddr  <= '0;
            bus.oDataW <= '0;
        end else begin
            bus.oWE <= 1'b0;
            if (bus.iFlush) begin
                state  <= IDLE;
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                // Push and LOAD in the same cycle cancel out.
                level <= level + PW'(push) - PW'(state == LOAD);

                case (state)
                    IDLE: begin
                        if (rd_en) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        cnt      <= rd_dat[EW-1:13];
                        lat_addr <= rd_dat[12:8];
                        lat_data <= rd_dat[7:0];
                        rd_ptr   <= rd_ptr + PW'(1);
                        state    <= WAIT;
                    end
                    WAIT: begin
                        // Pause freezes both the countdown and the exit at zero.
                        if (!pause) begin
                            if (cnt == '0) begin
                                state <= ISSUE;
                            end else if (bus.clkEn) begin
                                cnt <= cnt - DELAY_W'(1);
                            end
                        end
                    end
                    ISSUE: begin
                        bus.oWE    <= 1'b1;
                        bus.oAddr  <= lat_addr;
                        bus.oDataW <= lat_data;
                        // Chaining straight into LOAD makes the next delay
                        // count from this write.
                        state      <= rd_en ? LOAD : IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sid_write_queue.sv
// Directed self-checking bench for sid_write_queue.
// Latency: n/a (bench).
// Backpressure: host model samples oReady before each push attempt.
`timescale 1ns/1ps
module tb_sid_write_queue;
    localparam int DEPTH   = 256;
    localparam int DELAY_W = 16;

    logic clk   = 1'b0;
    logic iRstN = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   ce_auto = 1'b0;
    int   div     = 0;

    logic [12:0] we_q[$];
    int          we_cyc_q[$];
    int          tick_q[$];

    sid_write_queue_if #(.DEPTH(DEPTH), .DELAY_W(DELAY_W)) bus();

    sid_write_queue #(.DEPTH(DEPTH), .DELAY_W(DELAY_W)) dut (
        .clk   (clk),
        .iRstN (iRstN),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edge counter, clkEn tick log and write-strobe log (sampled 1 ns after the edge).
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.clkEn) tick_q.push_back(cyc);
        #1;
        if (bus.oWE) begin
            we_q.push_back({bus.oAddr, bus.oDataW});
            we_cyc_q.push_back(cyc);
        end
    end

    // Free-running 1-in-16 clkEn when enabled; otherwise tasks drive clkEn directly.
    always @(negedge clk) begin
        if (ce_auto) begin
            bus.clkEn = (div % 16 == 15);
            div = div + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Called at a negedge; drives one push attempt for one cycle and returns at the next negedge.
    task automatic push(input logic [15:0] d, input logic [4:0] a, input logic [7:0] v, output bit acc);
        acc        = bus.oReady;
        bus.iValid = 1'b1;
        bus.iDelay = d;
        bus.iAddr  = a;
        bus.iData  = v;
        @(negedge clk);
        bus.iValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        we_q.delete();
        we_cyc_q.delete();
        tick_q.delete();
    endtask

    task automatic test_reset();
        #2 iRstN = 1'b0;
        idle(2);
        checks++; if (bus.oWE !== 1'b0) begin errors++; $display("FAIL reset_we: got %0h expected 0", bus.oWE); end
        checks++; if (bus.oAddr !== 5'h00) begin errors++; $display("FAIL reset_addr: got %0h expected 0", bus.oAddr); end
        checks++; if (bus.oDataW !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.oDataW); end
        checks++; if (bus.oLevel !== 9'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.oLevel); end
        checks++; if (bus.oReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h expected 1", bus.oReady); end
        iRstN = 1'b1;
        idle(2);
    endtask

    task automatic test_single();
        bit acc;
        int e0;
        clear_logs();
        push(16'd0, 5'h18, 8'h0F, acc);
        e0 = cyc;
        idle(12);
        checks++; if (we_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d strobes expected 1", we_q.size()); end
        checks++; if (we_q.size() < 1 || we_q[0] !== {5'h18, 8'h0F}) begin errors++; $display("FAIL single_data: got %0h expected %0h", (we_q.size() > 0) ? we_q[0] : 13'h0, {5'h18, 8'h0F}); end
        checks++; if (we_cyc_q.size() < 1 || we_cyc_q[0] != e0 + 4) begin errors++; $display("FAIL single_latency: got edge %0d expected %0d", (we_cyc_q.size() > 0) ? we_cyc_q[0] : -1, e0 + 4); end
        checks++; if (bus.oLevel !== 9'd0) begin errors++; $display("FAIL single_level: got %0d expected 0", bus.oLevel); end
    endtask

    task automatic test_delay();
        bit acc;
        int w1, n, k;
        clear_logs();
        ce_auto = 1'b1;
        push(16'd0, 5'h00, 8'h11, acc);
        push(16'd5, 5'h01, 8'h22, acc);
        for (int i = 0; i < 400 && we_q.size() < 2; i++) @(negedge clk);
        idle(60);
        ce_auto   = 1'b0;
        bus.clkEn = 1'b0;
        w1 = (we_cyc_q.size() > 0) ? we_cyc_q[0] : 0;
        n  = 0;
        k  = -100;
        // Entry 2 is loaded at edge w1+1, so WAIT samples clkEn from edge w1+2 on.
        foreach (tick_q[j]) begin
            if (tick_q[j] >= w1 + 2) begin
                n++;
                if (n == 5) k = tick_q[j];
            end
        end
        checks++; if (we_q.size() != 2) begin errors++; $display("FAIL delay_count: got %0d strobes expected 2", we_q.size()); end
        checks++; if (we_q.size() < 1 || we_q[0] !== {5'h00, 8'h11}) begin errors++; $display("FAIL delay_first_data: got %0h expected %0h", (we_q.size() > 0) ? we_q[0] : 13'h0, {5'h00, 8'h11}); end
        checks++; if (we_q.size() < 2 || we_q[1] !== {5'h01, 8'h22}) begin errors++; $display("FAIL delay_second_data: got %0h expected %0h", (we_q.size() > 1) ? we_q[1] : 13'h0, {5'h01, 8'h22}); end
        checks++; if (we_cyc_q.size() < 2 || we_cyc_q[1] != k + 2) begin errors++; $display("FAIL delay_timing: got edge %0d expected %0d", (we_cyc_q.size() > 1) ? we_cyc_q[1] : -1, k + 2); end
    endtask

    task automatic test_flush();
        bit acc;
        int e0;
        clear_logs();
        bus.clkEn = 1'b0;
        for (int i = 0; i < 3; i++) push(16'd1000, 5'(i + 2), 8'(8'h30 + i), acc);
        idle(5);
        checks++; if (bus.oLevel !== 9'd2) begin errors++; $display("FAIL flush_prelevel: got %0d expected 2", bus.oLevel); end
        bus.iFlush = 1'b1;
        push(16'd0, 5'h07, 8'h77, acc);
        bus.iFlush = 1'b0;
        checks++; if (bus.oLevel !== 9'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", bus.oLevel); end
        checks++; if (bus.oReady !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0h expected 1", bus.oReady); end
        idle(30);
        checks++; if (we_q.size() != 0) begin errors++; $display("FAIL flush_no_write: got %0d strobes expected 0", we_q.size()); end
        checks++; if (bus.oLevel !== 9'd0) begin errors++; $display("FAIL flush_push_dropped: got level %0d expected 0", bus.oLevel); end
        // Flush landing on the ISSUE edge (acceptance + 4) must suppress the strobe.
        push(16'd0, 5'h0C, 8'hC3, acc);
        idle(3);
        bus.iFlush = 1'b1;
        @(negedge clk);
        bus.iFlush = 1'b0;
        idle(10);
        checks++; if (we_q.size() != 0) begin errors++; $display("FAIL flush_issue_suppressed: got %0d strobes expected 0", we_q.size()); end
        // Queue must restart cleanly from IDLE.
        push(16'd0, 5'h0D, 8'hD4, acc);
        e0 = cyc;
        idle(10);
        checks++; if (we_q.size() != 1 || we_q[0] !== {5'h0D, 8'hD4}) begin errors++; $display("FAIL flush_restart_data: got %0d strobes first %0h expected 1 strobe %0h", we_q.size(), (we_q.size() > 0) ? we_q[0] : 13'h0, {5'h0D, 8'hD4}); end
        checks++; if (we_cyc_q.size() < 1 || we_cyc_q[0] != e0 + 4) begin errors++; $display("FAIL flush_restart_latency: got edge %0d expected %0d", (we_cyc_q.size() > 0) ? we_cyc_q[0] : -1, e0 + 4); end
    endtask

    task automatic test_full();
        bit acc;
        int n_acc;
        logic [12:0] exp_q[$];
        clear_logs();
        bus.clkEn = 1'b0;
        // Blocker entry parks the FSM in WAIT so the FIFO can fill completely.
        push(16'd1, 5'h1F, 8'hEE, acc);
        exp_q.push_back({5'h1F, 8'hEE});
        idle(4);
        n_acc = 0;
        for (int i = 0; i < DEPTH; i++) begin
            push(16'd0, 5'(i), 8'(i * 3 + 1), acc);
            if (acc) begin
                n_acc++;
                exp_q.push_back({5'(i), 8'(i * 3 + 1)});
            end
        end
        checks++; if (n_acc != DEPTH) begin errors++; $display("FAIL full_accepted: got %0d expected %0d", n_acc, DEPTH); end
        checks++; if (bus.oLevel !== 9'd256) begin errors++; $display("FAIL full_level: got %0d expected 256", bus.oLevel); end
        checks++; if (bus.oReady !== 1'b0) begin errors++; $display("FAIL full_ready: got %0h expected 0", bus.oReady); end
        push(16'd0, 5'h15, 8'h99, acc);
        checks++; if (bus.oLevel !== 9'd256) begin errors++; $display("FAIL full_reject: got level %0d expected 256", bus.oLevel); end
        // One clkEn tick at edge A releases the blocker: ISSUE A+1, LOAD A+2, slot freed at A+3.
        bus.clkEn = 1'b1;
        @(negedge clk);
        bus.clkEn = 1'b0;
        idle(2);
        checks++; if (bus.oReady !== 1'b0) begin errors++; $display("FAIL full_ready_during_load: got %0h expected 0", bus.oReady); end
        @(negedge clk);
        checks++; if (bus.oReady !== 1'b1) begin errors++; $display("FAIL full_ready_after_load: got %0h expected 1", bus.oReady); end
        checks++; if (bus.oLevel !== 9'd255) begin errors++; $display("FAIL full_level_after_load: got %0d expected 255", bus.oLevel); end
        push(16'd0, 5'h0E, 8'h5A, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL full_extra_push: got ready %0h expected 1", acc); end
        if (acc) exp_q.push_back({5'h0E, 8'h5A});
        for (int i = 0; i < 1500 && we_q.size() < exp_q.size(); i++) @(negedge clk);
        idle(10);
        checks++; if (we_q.size() != exp_q.size()) begin errors++; $display("FAIL full_issue_count: got %0d expected %0d", we_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size() && j < we_q.size(); j++) begin
            checks++; if (we_q[j] !== exp_q[j]) begin errors++; $display("FAIL full_order[%0d]: got %0h expected %0h", j, we_q[j], exp_q[j]); end
        end
        checks++; if (bus.oLevel !== 9'd0) begin errors++; $display("FAIL full_drained: got level %0d expected 0", bus.oLevel); end
    endtask

    task automatic test_async_reset();
        bit acc;
        bit seen;
        int e0;
        clear_logs();
        push(16'd0, 5'h0A, 8'h55, acc);
        push(16'd0, 5'h0B, 8'h66, acc);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.oWE === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL areset_wait: got no strobe within 20 clk expected one"); end
        #2 iRstN = 1'b0;
        #1;
        checks++; if (bus.oWE !== 1'b0) begin errors++; $display("FAIL areset_we: got %0h expected 0", bus.oWE); end
        checks++; if (bus.oAddr !== 5'h00 || bus.oDataW !== 8'h00) begin errors++; $display("FAIL areset_outputs: got %0h/%0h expected 0/0", bus.oAddr, bus.oDataW); end
        checks++; if (bus.oLevel !== 9'd0 || bus.oReady !== 1'b1) begin errors++; $display("FAIL areset_level: got level %0d ready %0h expected 0/1", bus.oLevel, bus.oReady); end
        @(negedge clk);
        iRstN = 1'b1;
        idle(15);
        checks++; if (we_q.size() != 1) begin errors++; $display("FAIL areset_queue_cleared: got %0d strobes expected 1", we_q.size()); end
        push(16'd0, 5'h03, 8'h3C, acc);
        e0 = cyc;
        idle(10);
        checks++; if (we_q.size() != 2 || we_q[1] !== {5'h03, 8'h3C}) begin errors++; $display("FAIL areset_restart_data: got %0d strobes last %0h expected 2 strobes %0h", we_q.size(), (we_q.size() > 1) ? we_q[1] : 13'h0, {5'h03, 8'h3C}); end
        checks++; if (we_cyc_q.size() < 2 || we_cyc_q[1] != e0 + 4) begin errors++; $display("FAIL areset_restart_latency: got edge %0d expected %0d", (we_cyc_q.size() > 1) ? we_cyc_q[1] : -1, e0 + 4); end
    endtask

`ifdef SID_WRQ_PAUSE_EN
    // Single clkEn pulse sampled at the returned edge number.
    task automatic tick(output int t);
        bus.clkEn = 1'b1;
        @(negedge clk);
        bus.clkEn = 1'b0;
        t = cyc;
        idle(2);
    endtask

    task automatic test_pause();
        bit acc;
        int t, r;
        clear_logs();
        bus.iPause = 1'b0;
        push(16'd4, 5'h04, 8'h44, acc);
        idle(4);
        tick(t);
        tick(t);
        bus.iPause = 1'b1;
        for (int i = 0; i < 10; i++) tick(t);
        bus.iPause = 1'b0;
        tick(t);
        checks++; if (we_q.size() != 0) begin errors++; $display("FAIL pause_early: got %0d strobes expected 0", we_q.size()); end
        tick(t);
        idle(2);
        checks++; if (we_q.size() != 1 || we_q[0] !== {5'h04, 8'h44}) begin errors++; $display("FAIL pause_data: got %0d strobes first %0h expected 1 strobe %0h", we_q.size(), (we_q.size() > 0) ? we_q[0] : 13'h0, {5'h04, 8'h44}); end
        checks++; if (we_cyc_q.size() < 1 || we_cyc_q[0] != t + 2) begin errors++; $display("FAIL pause_timing: got edge %0d expected %0d", (we_cyc_q.size() > 0) ? we_cyc_q[0] : -1, t + 2); end
        // Zero-delay entry held in WAIT by pause, released at edge r.
        bus.iPause = 1'b1;
        push(16'd0, 5'h05, 8'h55, acc);
        idle(15);
        checks++; if (we_q.size() != 1) begin errors++; $display("FAIL pause_defer: got %0d strobes expected 1", we_q.size()); end
        checks++; if (bus.oLevel !== 9'd0) begin errors++; $display("FAIL pause_level: got %0d expected 0", bus.oLevel); end
        bus.iPause = 1'b0;
        @(negedge clk);
        r = cyc;
        idle(3);
        checks++; if (we_cyc_q.size() < 2 || we_cyc_q[1] != r + 1) begin errors++; $display("FAIL pause_release: got edge %0d expected %0d", (we_cyc_q.size() > 1) ? we_cyc_q[1] : -1, r + 1); end
    endtask
`endif

    initial begin
        bus.clkEn  = 1'b0;
        bus.iValid = 1'b0;
        bus.iDelay = '0;
        bus.iAddr  = '0;
        bus.iData  = '0;
        bus.iFlush = 1'b0;
`ifdef SID_WRQ_PAUSE_EN
        bus.iPause = 1'b0;
`endif
        test_reset();
        test_single();
        test_delay();
        test_flush();
        test_full();
        test_async_reset();
`ifdef SID_WRQ_PAUSE_EN
        test_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
